// File: rtl/alu_result_stage.sv
// ALU result stage: updates the accumulator and queues each result with zero/neg/carry flags.
// The head is registered (1-cycle res_in->out_valid); flush blocks intake until the queue drains.
module alu_result_stage #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             res_in,
   input  logic                     res_valid,
   output logic                     res_ready,
   input  logic [3:0]               acc_op,
   output logic [N-1:0]             acc_val,
   input  logic                     flush,
   output logic [N-1:0]             out_data,
   output logic [2:0]               out_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   mem_dat [DEPTH];
   logic [2:0]     mem_flg [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr, rd_nxt;
   logic           in_xfer, out_xfer;
   logic [N:0]     sum;
   logic [N-1:0]   acc_nxt;
   logic           new_carry;
   logic [2:0]     new_flags;
   logic [CW-1:0]  cnt_after_pop, count_nxt;

   assign res_ready = (state == RUN) && !flush && ((count < CW'(DEPTH)) || out_ready);
   assign in_xfer   = res_valid && res_ready;
   assign out_valid = (count != '0);
   assign out_xfer  = out_valid && out_ready;
   assign busy      = (state == DRAIN);

   assign sum = {1'b0, acc_val} + {1'b0, res_in};

   // Non-one-hot opcodes fall through to hold.
   always_comb begin
      acc_nxt   = acc_val;
      new_carry = 1'b0;
      if (in_xfer) begin
         case (acc_op)
            4'b1000: acc_nxt = '0;
            4'b0100: begin
               acc_nxt   = sum[N-1:0];
               new_carry = sum[N];
            end
            4'b0010: acc_nxt = res_in;
            default: acc_nxt = acc_val;
         endcase
      end
   end

   assign new_flags     = {new_carry, res_in[N-1], (res_in == '0)};
   assign rd_nxt        = out_xfer ? rd_ptr + AW'(1) : rd_ptr;
   assign cnt_after_pop = count - CW'(out_xfer);
   assign count_nxt     = cnt_after_pop + CW'(in_xfer);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush && !in_xfer) state_nxt = DRAIN;
         DRAIN:   if (count == '0 && !flush) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (in_xfer && !rst) begin
         mem_dat[wr_ptr] <= res_in;
         mem_flg[wr_ptr] <= new_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         acc_val   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_data  <= '0;
         out_flags <= '0;
      end else begin
         state   <= state_nxt;
         acc_val <= acc_nxt;
         count   <= count_nxt;
         rd_ptr  <= rd_nxt;
         if (in_xfer) wr_ptr <= wr_ptr + AW'(1);
         // A push into an otherwise empty queue becomes the head directly.
         if (in_xfer && cnt_after_pop == '0) begin
            out_data  <= res_in;
            out_flags <= new_flags;
         end else if (cnt_after_pop != '0) begin
            out_data  <= mem_dat[rd_nxt];
            out_flags <= mem_flg[rd_nxt];
         end
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with hand-computed expected values.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] res_in;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  acc_op;
   logic [15:0] acc_val;
   logic        flush;
   logic [15:0] out_data;
   logic [2:0]  out_flags;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  count;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   alu_result_stage #(.N(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .res_in(res_in), .res_valid(res_valid), .res_ready(res_ready),
      .acc_op(acc_op), .acc_val(acc_val), .flush(flush), .out_data(out_data),
      .out_flags(out_flags), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic [3:0] op);
      res_in    = d;
      acc_op    = op;
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; res_in = '0; res_valid = 1'b0; acc_op = '0; flush = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_acc", acc_val, 0);
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_flags", out_flags, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", res_ready, 1);

      // load 5, add 7, add 0xFFFF with out_ready high
      out_ready = 1'b1;
      push(16'd5, 4'b0010);
      chk("t1_acc5", acc_val, 5);
      chk("t1_data5", out_data, 5);
      chk("t1_flags5", out_flags, 3'b000);
      chk("t1_valid", out_valid, 1);
      push(16'd7, 4'b0100);
      chk("t1_acc12", acc_val, 12);
      chk("t1_data7", out_data, 7);
      chk("t1_flags7", out_flags, 3'b000);
      chk("t1_count1", count, 1);
      push(16'hFFFF, 4'b0100);
      chk("t1_acc11", acc_val, 11);
      chk("t1_dataffff", out_data, 16'hFFFF);
      chk("t1_flagsffff", out_flags, 3'b110);
      tick();
      chk("t1_empty", out_valid, 0);
      chk("t1_hold_data", out_data, 16'hFFFF);
      chk("t1_hold_flags", out_flags, 3'b110);

      // fill to DEPTH, then push and pop in the same cycle
      out_ready = 1'b0;
      push(16'd1, 4'b0001);
      push(16'd2, 4'b0001);
      push(16'd3, 4'b0001);
      push(16'd4, 4'b0001);
      chk("t2_full_count", count, 4);
      chk("t2_full_ready", res_ready, 0);
      chk("t2_head1", out_data, 1);
      out_ready = 1'b1;
      #1;
      chk("t2_ready_pop", res_ready, 1);
      push(16'd5, 4'b0001);
      chk("t2_pp_count", count, 4);
      chk("t2_head2", out_data, 2);
      tick();
      chk("t2_head3", out_data, 3);
      chk("t2_count3", count, 3);
      tick();
      chk("t2_head4", out_data, 4);
      tick();
      chk("t2_head5", out_data, 5);
      chk("t2_count1", count, 1);
      tick();
      chk("t2_drained", count, 0);
      chk("t2_acc_held", acc_val, 11);

      // clear with zero, hold with negative value
      push(16'd0, 4'b1000);
      chk("t3_acc_clr", acc_val, 0);
      chk("t3_flags_zero", out_flags, 3'b001);
      push(16'h8000, 4'b0001);
      chk("t3_acc_hold", acc_val, 0);
      chk("t3_data_neg", out_data, 16'h8000);
      chk("t3_flags_neg", out_flags, 3'b010);

      // multi-bit and zero opcodes behave as hold but still queue
      push(16'd3, 4'b0010);
      chk("t4_acc_load3", acc_val, 3);
      push(16'd9, 4'b0110);
      chk("t4_acc_multi", acc_val, 3);
      chk("t4_data9", out_data, 9);
      chk("t4_flags9", out_flags, 3'b000);
      push(16'd2, 4'b0000);
      chk("t4_acc_zero_op", acc_val, 3);
      chk("t4_data2", out_data, 2);
      tick();
      chk("t4_empty", count, 0);

      // flush pulse with two entries queued
      out_ready = 1'b0;
      push(16'h11, 4'b0001);
      push(16'h22, 4'b0001);
      chk("t5_count2", count, 2);
      flush = 1'b1; out_ready = 1'b1; res_valid = 1'b1; res_in = 16'h33; acc_op = 4'b0001;
      #1;
      chk("t5_flush_ready", res_ready, 0);
      tick();
      flush = 1'b0;
      #1;
      chk("t5_busy_a", busy, 1);
      chk("t5_count_a", count, 1);
      chk("t5_ready_a", res_ready, 0);
      chk("t5_head22", out_data, 16'h22);
      tick();
      chk("t5_busy_b", busy, 1);
      chk("t5_count_b", count, 0);
      chk("t5_valid_b", out_valid, 0);
      res_valid = 1'b0;
      tick();
      chk("t5_run", busy, 0);
      chk("t5_ready_run", res_ready, 1);
      chk("t5_nothing_written", count, 0);

      // flush with an empty queue still spends one cycle in DRAIN
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("t5e_busy", busy, 1);
      chk("t5e_ready", res_ready, 0);
      tick();
      chk("t5e_run", busy, 0);

      // reset mid-operation with a transfer pending
      out_ready = 1'b0;
      push(16'hA, 4'b0010);
      push(16'hB, 4'b0100);
      push(16'hC, 4'b0001);
      chk("t6_count3", count, 3);
      chk("t6_acc15", acc_val, 16'h15);
      rst = 1'b1; res_valid = 1'b1; res_in = 16'hD; acc_op = 4'b0010;
      tick();
      rst = 1'b0; res_valid = 1'b0;
      #1;
      chk("t6_count0", count, 0);
      chk("t6_valid0", out_valid, 0);
      chk("t6_acc0", acc_val, 0);
      chk("t6_data0", out_data, 0);
      chk("t6_flags0", out_flags, 0);
      chk("t6_busy0", busy, 0);
      tick();
      chk("t6_still_empty", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
